// File: rtl/mul_float.sv
// Multi-cycle IEEE-754 single-precision multiplier with a shift-add mantissa core.
// Define MUL_FLOAT_RNE_EN for round-to-nearest-even; the default build truncates.
module mul_float #(
  parameter int FLOAT_WIDTH = 32,
  parameter int EXP_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [FLOAT_WIDTH-1:0] a,
  input  logic [FLOAT_WIDTH-1:0] b,
  output logic [FLOAT_WIDTH-1:0] o,
  output logic                   nan,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   zero,
  output logic                   done,
  output logic                   busy
);

  localparam int FRAC_W  = FLOAT_WIDTH - EXP_WIDTH - 1;
  localparam int MANT_W  = FRAC_W + 1;
  localparam int PROD_W  = 2 * MANT_W;
  localparam int ESUM_W  = EXP_WIDTH + 2;
  localparam int CNT_W   = $clog2(MANT_W);
  localparam int BIAS    = (1 << (EXP_WIDTH - 1)) - 1;
  localparam int EXP_MAX = (1 << EXP_WIDTH) - 1;

  localparam logic signed [ESUM_W-1:0] EXP_MAX_S = ESUM_W'(EXP_MAX);
  localparam logic [FLOAT_WIDTH-1:0]   QNAN      = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

`ifdef MUL_FLOAT_RNE_EN
  localparam bit RNE_EN = 1'b1;
`else
  localparam bit RNE_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_NORM, S_ROUND, S_DONE} state_t;
  typedef enum logic [1:0] {SPC_NONE, SPC_NAN, SPC_INF, SPC_ZERO} spc_t;

  state_t                    state_q, state_d;
  spc_t                      spc_q, spc_d;
  logic [FLOAT_WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic                      sign_q, sign_d;
  logic signed [ESUM_W-1:0]  exp_q, exp_d;
  logic [PROD_W-1:0]         mcand_q, mcand_d, acc_q, acc_d;
  logic [MANT_W-1:0]         mplier_q, mplier_d, mant_q, mant_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      guard_q, guard_d, sticky_q, sticky_d;
  logic [FLOAT_WIDTH-1:0]    o_q, o_d;
  logic                      nan_q, nan_d, ovf_q, ovf_d, unf_q, unf_d, zero_q, zero_d;

  logic [EXP_WIDTH-1:0]      ea, eb;
  logic [FRAC_W-1:0]         fa, fb;
  logic                      a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic                      round_inc, carry;
  logic [MANT_W:0]           mant_r;
  logic [FRAC_W-1:0]         frac_n;
  logic signed [ESUM_W-1:0]  exp_r;

  assign ea     = a_q[FLOAT_WIDTH-2 -: EXP_WIDTH];
  assign eb     = b_q[FLOAT_WIDTH-2 -: EXP_WIDTH];
  assign fa     = a_q[FRAC_W-1:0];
  assign fb     = b_q[FRAC_W-1:0];
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);

  assign round_inc = RNE_EN & guard_q & (sticky_q | mant_q[0]);
  assign mant_r    = {1'b0, mant_q} + (MANT_W+1)'(round_inc);
  assign carry     = mant_r[MANT_W];
  assign frac_n    = carry ? mant_r[FRAC_W:1] : mant_r[FRAC_W-1:0];
  assign exp_r     = carry ? exp_q + ESUM_W'(1) : exp_q;

  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d  = state_q;
    spc_d    = spc_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mant_d   = mant_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    o_d      = o_q;
    nan_d    = nan_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    zero_d   = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sign_d   = a_q[FLOAT_WIDTH-1] ^ b_q[FLOAT_WIDTH-1];
        exp_d    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - ESUM_W'(BIAS);
        mcand_d  = {{MANT_W{1'b0}}, 1'b1, fa};
        mplier_d = {1'b1, fb};
        acc_d    = '0;
        cnt_d    = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) spc_d = SPC_NAN;
        else if (a_inf || b_inf)                                       spc_d = SPC_INF;
        else if (a_zero || b_zero)                                     spc_d = SPC_ZERO;
        else                                                           spc_d = SPC_NONE;
        // Special cases skip the multiply but still commit in ROUND, giving a 2-cycle path.
        state_d = (spc_d == SPC_NONE) ? S_MUL : S_ROUND;
      end
      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MANT_W - 1)) state_d = S_NORM;
      end
      S_NORM: begin
        if (acc_q[PROD_W-1]) begin
          mant_d   = acc_q[PROD_W-1 -: MANT_W];
          guard_d  = acc_q[PROD_W-1-MANT_W];
          sticky_d = |acc_q[PROD_W-2-MANT_W:0];
          exp_d    = exp_q + ESUM_W'(1);
        end else begin
          mant_d   = acc_q[PROD_W-2 -: MANT_W];
          guard_d  = acc_q[PROD_W-2-MANT_W];
          sticky_d = |acc_q[PROD_W-3-MANT_W:0];
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        nan_d  = 1'b0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        zero_d = 1'b0;
        unique case (spc_q)
          SPC_NAN: begin
            o_d   = QNAN;
            nan_d = 1'b1;
          end
          SPC_INF:  o_d = {sign_q, {EXP_WIDTH{1'b1}}, {FRAC_W{1'b0}}};
          SPC_ZERO: begin
            o_d    = {sign_q, {(FLOAT_WIDTH-1){1'b0}}};
            zero_d = 1'b1;
          end
          default: begin
            if (!exp_r[ESUM_W-1] && (exp_r >= EXP_MAX_S)) begin
              o_d   = {sign_q, {EXP_WIDTH{1'b1}}, {FRAC_W{1'b0}}};
              ovf_d = 1'b1;
            end else if (exp_r[ESUM_W-1] || (exp_r == '0)) begin
              o_d    = {sign_q, {(FLOAT_WIDTH-1){1'b0}}};
              unf_d  = 1'b1;
              zero_d = 1'b1;
            end else begin
              o_d = {sign_q, exp_r[EXP_WIDTH-1:0], frac_n};
            end
          end
        endcase
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q  <= S_IDLE;
      spc_q    <= SPC_NONE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      o_q      <= '0;
      nan_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      spc_q    <= spc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      o_q      <= o_d;
      nan_q    <= nan_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      zero_q   <= zero_d;
    end
  end

  assign o         = o_q;
  assign nan       = nan_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign zero      = zero_q;
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_float.sv
// Self-checking bench for mul_float: vector table plus latency, ignored-start and
// mid-operation reset sequences; results go through an expected-value queue.
module tb_mul_float;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] o;
  logic        nan, overflow, underflow, zero, done, busy;

  mul_float dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .o(o),
    .nan(nan), .overflow(overflow), .underflow(underflow), .zero(zero),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] o;
    logic [3:0]  flags;  // {nan, overflow, underflow, zero}
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] o;
    logic [3:0]  flags;
  } exp_t;

  localparam int NVEC = 16;
  localparam int LAT_N = 27;
  localparam int LAT_S = 2;

`ifdef MUL_FLOAT_RNE_EN
  localparam logic [31:0] RND_O = 32'h3FC0_0002;
`else
  localparam logic [31:0] RND_O = 32'h3FC0_0001;
`endif

  vec_t vecs [NVEC];
  exp_t sb_q [$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1, expected no pending result");
      end else begin
        e = sb_q.pop_front();
        check("result_o", o, e.o);
        check("result_flags", {28'd0, nan, overflow, underflow, zero}, {28'd0, e.flags});
      end
    end
  end

  task automatic issue(input logic [31:0] va, input logic [31:0] vb, input bit push,
                       input logic [31:0] eo, input logic [3:0] ef);
    exp_t e;
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    if (push) begin
      e.o = eo;
      e.flags = ef;
      sb_q.push_back(e);
    end
    @(posedge clk);  // E0
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done(input string nm, input int lat0, input int exp_lat);
    int lat = lat0;
    bit seen = 1'b0;
    bit busy_ok = 1'b1;
    while (!seen && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (!busy) busy_ok = 1'b0;
      if (done) seen = 1'b1;
    end
    check({nm, "_latency"}, seen ? lat : -1, exp_lat);
    check({nm, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
    @(posedge clk);
    #1;
    check({nm, "_idle_after"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h40A0_0000, 32'h40A0_0000, 32'h41C8_0000, 4'b0000, LAT_N};
    vecs[1]  = '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0100, LAT_N};
    vecs[2]  = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0011, LAT_N};
    vecs[3]  = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, LAT_S};
    vecs[4]  = '{32'h3FC0_0000, 32'h3F80_0001, RND_O,         4'b0000, LAT_N};
    vecs[5]  = '{32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, LAT_S};
    vecs[6]  = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, LAT_S};
    vecs[7]  = '{32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 4'b0001, LAT_S};
    vecs[8]  = '{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0001, LAT_S};
    vecs[9]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000, LAT_N};
    vecs[10] = '{32'h4000_0000, 32'hC000_0000, 32'hC080_0000, 4'b0000, LAT_N};
    vecs[11] = '{32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 4'b0000, LAT_N};
    vecs[12] = '{32'h3F80_0000, 32'h0080_0000, 32'h0080_0000, 4'b0000, LAT_N};
    vecs[13] = '{32'h3F00_0000, 32'h0080_0000, 32'h0000_0000, 4'b0011, LAT_N};
    vecs[14] = '{32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F7F_FFFF, 4'b0000, LAT_N};
    vecs[15] = '{32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 4'b0100, LAT_N};

    repeat (3) @(posedge clk);
    #1;
    check("reset_o", o, 32'h0);
    check("reset_flags_done_busy", {26'd0, nan, overflow, underflow, zero, done, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].a, vecs[i].b, 1'b1, vecs[i].o, vecs[i].flags);
      wait_done($sformatf("vec%0d", i), 0, vecs[i].lat);
    end

    // Start pulse at E5 while busy must be ignored.
    begin
      int dc;
      issue(32'h3F80_0000, 32'hC040_0000, 1'b1, 32'hC040_0000, 4'b0000);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      a = '0;
      b = '0;
      @(posedge clk);  // E5
      #1;
      start = 1'b0;
      wait_done("ignored_start", 5, LAT_N);
      dc = done_cnt;
      repeat (40) @(posedge clk);
      #1;
      check("ignored_start_single_done", done_cnt, dc);
      check("ignored_start_o_held", o, 32'hC040_0000);
    end

    // Reset at E10 aborts the operation and clears the outputs.
    begin
      int dc;
      dc = done_cnt;
      issue(32'h40A0_0000, 32'h4040_0000, 1'b0, '0, '0);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);  // E10
      #1;
      rst = 1'b0;
      check("abort_o", o, 32'h0);
      check("abort_flags_done_busy", {26'd0, nan, overflow, underflow, zero, done, busy}, 32'd0);
      repeat (40) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt, dc);
      issue(32'h40A0_0000, 32'h40A0_0000, 1'b1, 32'h41C8_0000, 4'b0000);
      wait_done("restart", 0, LAT_N);
    end

    repeat (2) @(posedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
